// File: rtl/enc_pkg.sv
// Shared constants and helpers for the one-hot/priority encoder stream.
// Used by every file of the block; MODE values and counter width live here.
package enc_pkg;

  localparam int ENC_MODE_STRICT   = 0;
  localparam int ENC_MODE_PRIORITY = 1;
  localparam int ERR_CNT_W         = 16;

  // Code width for an N-line encoder; a 2-line encoder still needs one bit.
  function automatic int enc_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_encoder_stream_if.sv
// Streaming bus for the encoder: input vector side and encoded result side.
// slave is the encoder's view, master is the surrounding producer/consumer.
interface onehot_encoder_stream_if import enc_pkg::*; #(
  parameter int N = 10
);

  localparam int W = enc_width(N);

  // Valid/ready on both sides: a beat moves on a rising edge where valid and
  // ready are both high; in_ready may depend combinationally on out_ready.
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic         out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_err
  );

endinterface

// File: rtl/onehot_encode_core.sv
// Combinational N-line encoder: strict one-hot or highest-set-bit priority.
// Invalid inputs give code 0 with err set.
module onehot_encode_core import enc_pkg::*; #(
  parameter int N    = 10,
  parameter int W    = enc_width(N),
  parameter int MODE = ENC_MODE_STRICT
) (
  input  logic [N-1:0] in_data,
  output logic [W-1:0] code,
  output logic         err
);

  logic [W-1:0] top_idx;

  // Later iterations override earlier ones, so the highest set bit wins.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in_data[i]) begin
        top_idx = W'(i);
      end
    end
  end

  generate
    if (MODE == ENC_MODE_PRIORITY) begin : g_priority
      assign code = top_idx;
      assign err  = ~|in_data;
    end else begin : g_strict
      logic onehot;
      assign onehot = ($countones(in_data) == 1);
      assign code   = onehot ? top_idx : '0;
      assign err    = ~onehot;
    end
  endgenerate

endmodule

// File: rtl/onehot_encoder_stream.sv
// Registered one-hot/priority encoder with valid/ready handshake on both sides.
// Define ENC_ERR_COUNT_EN to add err_clr/err_count and a saturating error counter.
module onehot_encoder_stream import enc_pkg::*; #(
  parameter int N    = 10,
  parameter int MODE = ENC_MODE_STRICT
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ENC_ERR_COUNT_EN
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  onehot_encoder_stream_if.slave bus
);

  localparam int W = enc_width(N);

  logic [W-1:0] core_code;
  logic         core_err;
  logic         accept;
  logic         out_valid_q;
  logic [W-1:0] out_code_q;
  logic         out_err_q;

  onehot_encode_core #(
    .N    (N),
    .W    (W),
    .MODE (MODE)
  ) u_core (
    .in_data (bus.in_data),
    .code    (core_code),
    .err     (core_err)
  );

  // Single output register: a new input can enter whenever the held result
  // is absent or leaving this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_code_q  <= core_code;
      out_err_q   <= core_err;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_err   = out_err_q;

`ifdef ENC_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt_q <= '0;
    end else if (accept && core_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Bench for onehot_encoder_stream: four builds (N=10 strict/priority, N=16 strict,
// N=2 priority) share one stimulus stream and are checked against a reference model.
module tb_onehot_encoder_stream;
  import enc_pkg::*;

  localparam int ND = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] data      = '0;

  int total = 0;
  int bad   = 0;
  bit live  = 1'b0;

  always #5 clk = ~clk;

  onehot_encoder_stream_if #(.N(10)) if_a ();
  onehot_encoder_stream_if #(.N(10)) if_b ();
  onehot_encoder_stream_if #(.N(16)) if_c ();
  onehot_encoder_stream_if #(.N(2))  if_d ();

  assign if_a.in_valid = in_valid;
  assign if_b.in_valid = in_valid;
  assign if_c.in_valid = in_valid;
  assign if_d.in_valid = in_valid;
  assign if_a.out_ready = out_ready;
  assign if_b.out_ready = out_ready;
  assign if_c.out_ready = out_ready;
  assign if_d.out_ready = out_ready;
  assign if_a.in_data = data[9:0];
  assign if_b.in_data = data[9:0];
  assign if_c.in_data = data;
  assign if_d.in_data = data[1:0];

`ifdef ENC_ERR_COUNT_EN
  logic        err_clr = 1'b0;
  logic [15:0] cnt_act [ND];
`endif

  onehot_encoder_stream #(.N(10), .MODE(ENC_MODE_STRICT)) dut_a (
    .clk (clk), .rst (rst),
`ifdef ENC_ERR_COUNT_EN
    .err_clr (err_clr), .err_count (cnt_act[0]),
`endif
    .bus (if_a)
  );
  onehot_encoder_stream #(.N(10), .MODE(ENC_MODE_PRIORITY)) dut_b (
    .clk (clk), .rst (rst),
`ifdef ENC_ERR_COUNT_EN
    .err_clr (err_clr), .err_count (cnt_act[1]),
`endif
    .bus (if_b)
  );
  onehot_encoder_stream #(.N(16), .MODE(ENC_MODE_STRICT)) dut_c (
    .clk (clk), .rst (rst),
`ifdef ENC_ERR_COUNT_EN
    .err_clr (err_clr), .err_count (cnt_act[2]),
`endif
    .bus (if_c)
  );
  onehot_encoder_stream #(.N(2), .MODE(ENC_MODE_PRIORITY)) dut_d (
    .clk (clk), .rst (rst),
`ifdef ENC_ERR_COUNT_EN
    .err_clr (err_clr), .err_count (cnt_act[3]),
`endif
    .bus (if_d)
  );

  logic [ND-1:0] act_valid, act_ready, act_err;
  logic [7:0]    act_code [ND];

  assign act_valid = {if_d.out_valid, if_c.out_valid, if_b.out_valid, if_a.out_valid};
  assign act_ready = {if_d.in_ready, if_c.in_ready, if_b.in_ready, if_a.in_ready};
  assign act_err   = {if_d.out_err, if_c.out_err, if_b.out_err, if_a.out_err};
  assign act_code[0] = 8'(if_a.out_code);
  assign act_code[1] = 8'(if_b.out_code);
  assign act_code[2] = 8'(if_c.out_code);
  assign act_code[3] = 8'(if_d.out_code);

  int nbits [ND] = '{10, 10, 16, 2};
  bit prio  [ND] = '{1'b0, 1'b1, 1'b0, 1'b1};

  // Reference: {err, code[7:0]} from the encoding rules, using integer math.
  function automatic logic [8:0] ref_enc(input int n, input bit pr, input logic [15:0] d);
    int v;
    v = int'(d) & ((1 << n) - 1);
    if (v == 0) return {1'b1, 8'd0};
    if (pr) return {1'b0, 8'($clog2(v + 1) - 1)};
    if ((v & (v - 1)) == 0) return {1'b0, 8'($clog2(v))};
    return {1'b1, 8'd0};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: one-deep expected result per build plus expected counter.
  bit         exp_valid [ND];
  logic [8:0] exp_word  [ND];
`ifdef ENC_ERR_COUNT_EN
  int         exp_cnt   [ND];
`endif

  always @(negedge clk) begin
    bit         rdy;
    logic [8:0] r;
    for (int d = 0; d < ND; d++) begin
      if (live) begin
        check($sformatf("in_ready[%0d]", d), int'(act_ready[d]), int'(!exp_valid[d] || out_ready));
        check($sformatf("out_valid[%0d]", d), int'(act_valid[d]), int'(exp_valid[d]));
        if (exp_valid[d]) begin
          check($sformatf("out_code[%0d]", d), int'(act_code[d]), int'(exp_word[d][7:0]));
          check($sformatf("out_err[%0d]", d), int'(act_err[d]), int'(exp_word[d][8]));
        end
`ifdef ENC_ERR_COUNT_EN
        check($sformatf("err_count[%0d]", d), int'(cnt_act[d]), exp_cnt[d]);
`endif
      end
      rdy = !exp_valid[d] || out_ready;
      r   = ref_enc(nbits[d], prio[d], data);
      if (rst) begin
        exp_valid[d] = 1'b0;
`ifdef ENC_ERR_COUNT_EN
        exp_cnt[d] = 0;
`endif
      end else begin
`ifdef ENC_ERR_COUNT_EN
        if (err_clr) exp_cnt[d] = 0;
        else if (in_valid && rdy && r[8] && exp_cnt[d] < 65535) exp_cnt[d]++;
`endif
        if (in_valid && rdy) begin
          exp_valid[d] = 1'b1;
          exp_word[d]  = r;
        end else if (out_ready) begin
          exp_valid[d] = 1'b0;
        end
      end
    end
    live = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 5))
      0:       return '0;
      1, 2:    return 16'(1) << $urandom_range(0, 15);
      3:       return (16'(1) << $urandom_range(0, 9)) | (16'(1) << $urandom_range(0, 9));
      4:       return 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("reset out_valid", int'(if_a.out_valid), 0);
    check("reset out_code", int'(if_a.out_code), 0);
    check("reset out_err", int'(if_a.out_err), 0);
    check("reset in_ready", int'(if_a.in_ready), 1);
`ifdef ENC_ERR_COUNT_EN
    check("reset err_count", int'(cnt_act[0]), 0);
`endif

    in_valid = 1'b1; out_ready = 1'b1; data = 16'b0000001000;
    step();
    check("hot3 valid", int'(if_a.out_valid), 1);
    check("hot3 code", int'(if_a.out_code), 3);
    check("hot3 err", int'(if_a.out_err), 0);

    data = 16'b0000000110;
    step();
    check("two-hot strict code", int'(if_a.out_code), 0);
    check("two-hot strict err", int'(if_a.out_err), 1);
    check("two-hot prio code", int'(if_b.out_code), 2);
    check("two-hot prio err", int'(if_b.out_err), 0);
`ifdef ENC_ERR_COUNT_EN
    check("two-hot err_count", int'(cnt_act[0]), 1);
`endif

    data = '0;
    step();
    check("zero strict code", int'(if_a.out_code), 0);
    check("zero strict err", int'(if_a.out_err), 1);
    check("zero prio code", int'(if_b.out_code), 0);
    check("zero prio err", int'(if_b.out_err), 1);
    in_valid = 1'b0;
    step();

    // Backpressure: hold a result while the consumer stalls.
    in_valid = 1'b1; out_ready = 1'b0; data = 16'h0200;
    step();
    data = 16'h0005;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall code", int'(if_a.out_code), 9);
      check("stall valid", int'(if_a.out_valid), 1);
      check("stall in_ready", int'(if_a.in_ready), 0);
    end
    out_ready = 1'b1; data = 16'h0001;
    #1;
    check("release in_ready", int'(if_a.in_ready), 1);
    step();
    check("release code", int'(if_a.out_code), 0);
    check("release err", int'(if_a.out_err), 0);
    check("release valid", int'(if_a.out_valid), 1);
    in_valid = 1'b0;
    step();

    // Reset with a stalled result and a pending input.
    in_valid = 1'b1; out_ready = 1'b0; data = 16'h0100;
    step();
    check("pre-reset code", int'(if_a.out_code), 8);
    rst = 1'b1; data = 16'h0004;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("post-reset valid", int'(if_a.out_valid), 0);
    check("post-reset in_ready", int'(if_a.in_ready), 1);
`ifdef ENC_ERR_COUNT_EN
    check("post-reset err_count", int'(cnt_act[0]), 0);
`endif
    out_ready = 1'b1;
    step();

    // Every single-hot input on the 16- and 2-line builds.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; data = 16'(1) << i;
      step();
      check($sformatf("n16 hot%0d code", i), int'(if_c.out_code), i);
      check($sformatf("n16 hot%0d err", i), int'(if_c.out_err), 0);
      if (i < 2) begin
        check($sformatf("n2 hot%0d code", i), int'(if_d.out_code), i);
        check($sformatf("n2 hot%0d err", i), int'(if_d.out_err), 0);
      end
    end
    in_valid = 1'b0;
    step();

    repeat (3000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      data      = rand_data();
`ifdef ENC_ERR_COUNT_EN
      err_clr   = ($urandom_range(0, 49) == 0);
`endif
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
`ifdef ENC_ERR_COUNT_EN
    err_clr = 1'b0;
`endif
    step();

`ifdef ENC_ERR_COUNT_EN
    in_valid = 1'b1; data = '0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    repeat (65540) step();
    check("counter saturated", int'(cnt_act[0]), 65535);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clear beats increment", int'(cnt_act[0]), 0);
    in_valid = 1'b0;
    step();
`endif

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
